// File: rtl/tile_fetch_engine_pkg.sv
// +----------------------------------------------------------------------------+
// | fetch_pkg : shared constants for the tile fetch engine                     |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  localparam int CH_WBI     = 0;
  localparam int CH_QKV     = 1;
  localparam int CH_WBI_FFN = 2;
  localparam int CH_SV      = 3;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/tile_fetch_engine_if.sv
// +----------------------------------------------------------------------------+
// | tile_fetch_engine_if : valid/ready output stream of the tile fetch engine  |
// | Revision             : 1.0                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

interface tile_fetch_engine_if #(
  parameter int DATA_WIDTH = 256
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (output m_data, output m_valid, output m_last, input  m_ready);
  modport slave  (input  m_data, input  m_valid, input  m_last, output m_ready);
endinterface

`default_nettype wire

// File: rtl/tile_fetch_engine_rd_fifo.sv
// +----------------------------------------------------------------------------+
// | fetch_rd_fifo : synchronous FIFO absorbing BRAM returns under backpressure |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_rd_fifo #(
  parameter int  WIDTH = 257,
  parameter int  DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign count     = r_count;
  // A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tile_fetch_engine.sv
// +----------------------------------------------------------------------------+
// | tile_fetch_engine : multi-channel BRAM tile reader, row-major or transposed|
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tile_fetch_engine
  import fetch_pkg::*;
#(
  parameter int  ADDR_WIDTH = 16,
  parameter int  DATA_WIDTH = 256,
  parameter int  N_CH       = 4,
  parameter int  RD_LATENCY = 2,
  parameter int  DIM_W      = 10,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CH_W-1:0]            cfg_ch_sel,
  input  logic [ADDR_WIDTH-1:0]      cfg_base_addr,
  input  logic [DIM_W-1:0]           cfg_rows,
  input  logic [DIM_W-1:0]           cfg_cols,
  input  logic [ADDR_WIDTH-1:0]      cfg_stride,
  input  logic                       cfg_transpose,
  output logic [N_CH-1:0]            bram_en,
  output logic [ADDR_WIDTH-1:0]      bram_addr,
  input  logic [N_CH*DATA_WIDTH-1:0] bram_dout,
  tile_fetch_engine_if.master        m_if,
  output logic                       busy,
  output logic                       done
);

  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  logic [1:0]            r_state;
  logic [CH_W-1:0]       r_ch;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_line;
  logic [ADDR_WIDTH-1:0] r_in_step;
  logic [ADDR_WIDTH-1:0] r_out_step;
  logic [DIM_W-1:0]      r_in_lim;
  logic [DIM_W-1:0]      r_out_lim;
  logic [DIM_W-1:0]      r_in_cnt;
  logic [DIM_W-1:0]      r_out_cnt;
  logic [RD_LATENCY-1:0] r_tag_v;
  logic [RD_LATENCY-1:0] r_tag_last;
  logic [CNT_W-1:0]      r_inflight;

  logic [CNT_W-1:0]      w_fifo_count;
  logic [CNT_W:0]        w_credit_sum;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic                  w_issue;
  logic                  w_in_end;
  logic                  w_out_end;
  logic                  w_arrive;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_arr_data;
  logic [DATA_WIDTH:0]   w_fifo_rdata;

  // A read may only issue if every outstanding word already has a FIFO slot reserved.
  assign w_credit_sum = {1'b0, r_inflight} + {1'b0, w_fifo_count};
  assign w_issue      = (r_state == c_st_issue) && (w_credit_sum < (CNT_W + 1)'(FIFO_DEPTH));
  assign w_in_end     = (r_in_cnt == r_in_lim - 1'b1);
  assign w_out_end    = (r_out_cnt == r_out_lim - 1'b1);
  assign w_arrive     = r_tag_v[RD_LATENCY-1];
  assign w_pop        = m_if.m_valid & m_if.m_ready;

  assign busy      = (r_state == c_st_issue) || (r_state == c_st_drain);
  assign done      = (r_state == c_st_done);
  assign bram_addr = r_addr;

  always_comb begin
    bram_en = '0;
    if (w_issue) begin
      bram_en[r_ch] = 1'b1;
    end
  end

  always_comb begin
    w_arr_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (r_ch == k[CH_W-1:0]) begin
        w_arr_data = bram_dout[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Inner/outer loop steps are swapped for transpose so one counter pair serves both orders.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_st_idle;
      r_ch       <= '0;
      r_addr     <= '0;
      r_line     <= '0;
      r_in_step  <= '0;
      r_out_step <= '0;
      r_in_lim   <= '0;
      r_out_lim  <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_ch       <= cfg_ch_sel;
            r_addr     <= cfg_base_addr;
            r_line     <= cfg_base_addr;
            r_in_step  <= cfg_transpose ? cfg_stride : ADDR_WIDTH'(1);
            r_out_step <= cfg_transpose ? ADDR_WIDTH'(1) : cfg_stride;
            r_in_lim   <= cfg_transpose ? cfg_rows : cfg_cols;
            r_out_lim  <= cfg_transpose ? cfg_cols : cfg_rows;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_state    <= ((cfg_rows == '0) || (cfg_cols == '0)) ? c_st_done : c_st_issue;
          end
        end
        c_st_issue: begin
          if (w_issue) begin
            if (w_in_end && w_out_end) begin
              r_state <= c_st_drain;
            end else if (w_in_end) begin
              r_in_cnt  <= '0;
              r_out_cnt <= r_out_cnt + 1'b1;
              r_line    <= r_line + r_out_step;
              r_addr    <= r_line + r_out_step;
            end else begin
              r_in_cnt <= r_in_cnt + 1'b1;
              r_addr   <= r_addr + r_in_step;
            end
          end
        end
        c_st_drain: begin
          if (w_pop && m_if.m_last) begin
            r_state <= c_st_done;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v    <= '0;
      r_tag_last <= '0;
      r_inflight <= '0;
    end else begin
      r_tag_v[0]    <= w_issue;
      r_tag_last[0] <= w_issue && w_in_end && w_out_end;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_tag_v[i]    <= r_tag_v[i-1];
        r_tag_last[i] <= r_tag_last[i-1];
      end
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_arrive);
    end
  end

  fetch_rd_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_arrive),
    .wdata ({r_tag_last[RD_LATENCY-1], w_arr_data}),
    .pop   (w_pop),
    .rdata (w_fifo_rdata),
    .count (w_fifo_count),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

  assign m_if.m_valid = ~w_fifo_empty;
  assign m_if.m_data  = w_fifo_rdata[DATA_WIDTH-1:0];
  assign m_if.m_last  = w_fifo_rdata[DATA_WIDTH];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_arrive && w_fifo_full && !w_pop));

endmodule

`default_nettype wire
